// File: rtl/serial_subtractor.sv
// Bit-serial A - B: one full-subtractor cell, registered borrow, LSB first, WIDTH cycles per result.
// Optional signed-overflow flag compiled in with SERIAL_SUB_OVF_EN; without it ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sr, sr_shift, d_msb;
  logic [WIDTH-1:0] diff_q;
  logic             br, bout_q;
  logic [CW-1:0]    cnt;
  logic             x, y, d, br_next, last, accept;

  assign x       = sa[0];
  assign y       = sb[0];
  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~(x ^ y) & br);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = in_valid && (state == IDLE);

  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = d;
    sr_shift         = (sr >> 1) | d_msb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Result is copied out on the final bit so it survives the SR clear at the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_shift;
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff_q <= sr_shift;
        bout_q <= br_next;
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  // On the final bit x/y are the operand sign bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_r <= 1'b0;
    else if ((state == RUN) && last) ovf_r <= (x != y) && (d != x);
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule
